memory_driver: RTL and testbench

Responder for the tree engines' simple memory request interface (mem_valid/mem_ready/mem_rd/mem_wr/mem_addr/mem_wr_data, read return on mem_rd_*). Converts each request into a single-beat AXI4 master transaction toward the node RAM and returns read data to the requesting engine. Sits between the insert/search/delete engines' interface mux and the AXI4 RAM.

---
 rtl/memory_driver.sv | 112 +++++++++++
 tb/tb_memory_driver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/memory_driver.sv
// memory_driver: turns single engine memory requests into single-beat AXI4 writes/reads toward the node RAM.
module memory_driver #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH/8,
  parameter int RAM_ID_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic                      mem_rd,
  input  logic                      mem_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
  output logic                      mem_rd_valid,
  input  logic                      mem_rd_ready,
  output logic [RAM_DATA_WIDTH-1:0] mem_rd_data,
  output logic                      mem_error,
  output logic [RAM_ID_WIDTH-1:0]   ram_awid,
  output logic [RAM_ADDR_WIDTH-1:0] ram_awaddr,
  output logic [7:0]                ram_awlen,
  output logic [2:0]                ram_awsize,
  output logic [1:0]                ram_awburst,
  output logic                      ram_awvalid,
  input  logic                      ram_awready,
  output logic [RAM_DATA_WIDTH-1:0] ram_wdata,
  output logic [RAM_STRB_WIDTH-1:0] ram_wstrb,
  output logic                      ram_wlast,
  output logic                      ram_wvalid,
  input  logic                      ram_wready,
  input  logic [1:0]                ram_bresp,
  input  logic                      ram_bvalid,
  output logic                      ram_bready,
  output logic [RAM_ID_WIDTH-1:0]   ram_arid,
  output logic [RAM_ADDR_WIDTH-1:0] ram_araddr,
  output logic [7:0]                ram_arlen,
  output logic [2:0]                ram_arsize,
  output logic [1:0]                ram_arburst,
  output logic                      ram_arvalid,
  input  logic                      ram_arready,
  input  logic [RAM_DATA_WIDTH-1:0] ram_rdata,
  input  logic [1:0]                ram_rresp,
  input  logic                      ram_rvalid,
  output logic                      ram_rready
);
  typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, READ, RD_RESP, RD_CPL} state_t;
  state_t state, state_nxt;
  logic [RAM_ADDR_WIDTH-1:0] addr;
  logic [RAM_DATA_WIDTH-1:0] wr_data;
  logic aw_done, w_done, accept, aw_hs, w_hs, b_hs, r_hs, err_set;
  assign ram_awid    = '0;
  assign ram_arid    = '0;
  assign ram_awlen   = '0;
  assign ram_arlen   = '0;
  assign ram_awsize  = 3'($clog2(RAM_STRB_WIDTH));
  assign ram_arsize  = 3'($clog2(RAM_STRB_WIDTH));
  assign ram_awburst = 2'b01;
  assign ram_arburst = 2'b01;
  assign ram_wstrb   = '1;
  assign ram_wlast   = ram_wvalid;
  assign ram_awaddr  = addr;
  assign ram_araddr  = addr;
  assign ram_wdata   = wr_data;
  // all handshake outputs come from registered state only, never from ready
  assign mem_ready    = (state == IDLE) && aresetn;
  assign ram_awvalid  = (state == WRITE) && !aw_done;
  assign ram_wvalid   = (state == WRITE) && !w_done;
  assign ram_bready   = state == WR_RESP;
  assign ram_arvalid  = state == READ;
  assign ram_rready   = state == RD_RESP;
  assign mem_rd_valid = state == RD_CPL;
  assign accept  = mem_valid && mem_ready;
  assign aw_hs   = ram_awvalid && ram_awready;
  assign w_hs    = ram_wvalid && ram_wready;
  assign b_hs    = ram_bvalid && ram_bready;
  assign r_hs    = ram_rvalid && ram_rready;
  assign err_set = (accept && (mem_rd == mem_wr)) || (b_hs && |ram_bresp) || (r_hs && |ram_rresp);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !accept ? IDLE : mem_wr ? WRITE : mem_rd ? READ : IDLE;
      WRITE:   state_nxt = ((aw_done || aw_hs) && (w_done || w_hs)) ? WR_RESP : WRITE;
      WR_RESP: state_nxt = ram_bvalid ? IDLE : WR_RESP;
      READ:    state_nxt = ram_arready ? RD_RESP : READ;
      RD_RESP: state_nxt = ram_rvalid ? RD_CPL : RD_RESP;
      RD_CPL:  state_nxt = mem_rd_ready ? IDLE : RD_CPL;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      addr        <= '0;
      wr_data     <= '0;
      mem_rd_data <= '0;
      mem_error   <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_done <= (state_nxt == WRITE) && (aw_done || aw_hs);
      w_done  <= (state_nxt == WRITE) && (w_done || w_hs);
      if (accept) begin
        addr    <= mem_addr;
        wr_data <= mem_wr_data;
      end
      if (r_hs) mem_rd_data <= ram_rdata;
      if (err_set) mem_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_memory_driver.sv
// tb_memory_driver: directed scoreboard bench for memory_driver with a scripted AXI RAM.
module tb_memory_driver;
  localparam int DW = 32, AW = 16, SW = 4, IW = 8;
  logic aclk = 0, aresetn = 0;
  logic mem_valid = 0, mem_rd = 0, mem_wr = 0, mem_rd_ready = 0;
  logic [AW-1:0] mem_addr = 0;
  logic [DW-1:0] mem_wr_data = 0;
  logic mem_ready, mem_rd_valid, mem_error;
  logic [DW-1:0] mem_rd_data;
  logic [IW-1:0] ram_awid, ram_arid;
  logic [AW-1:0] ram_awaddr, ram_araddr;
  logic [7:0] ram_awlen, ram_arlen;
  logic [2:0] ram_awsize, ram_arsize;
  logic [1:0] ram_awburst, ram_arburst;
  logic ram_awvalid, ram_wvalid, ram_wlast, ram_bready, ram_arvalid, ram_rready;
  logic [DW-1:0] ram_wdata;
  logic [SW-1:0] ram_wstrb;
  logic ram_awready = 0, ram_wready = 0, ram_bvalid = 0, ram_arready = 0, ram_rvalid = 0;
  logic [1:0] ram_bresp = 0, ram_rresp = 0;
  logic [DW-1:0] ram_rdata = 0;
  int checks = 0, errors = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic [AW-1:0] exp_aw[$], exp_ar[$];
  logic [DW-1:0] exp_w[$], exp_rd[$];

  always #5 aclk = ~aclk;

  memory_driver #(.RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .RAM_STRB_WIDTH(SW), .RAM_ID_WIDTH(IW)) dut (
    .aclk(aclk), .aresetn(aresetn), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_valid(mem_rd_valid),
    .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data), .mem_error(mem_error),
    .ram_awid(ram_awid), .ram_awaddr(ram_awaddr), .ram_awlen(ram_awlen), .ram_awsize(ram_awsize),
    .ram_awburst(ram_awburst), .ram_awvalid(ram_awvalid), .ram_awready(ram_awready),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_wlast(ram_wlast), .ram_wvalid(ram_wvalid),
    .ram_wready(ram_wready), .ram_bresp(ram_bresp), .ram_bvalid(ram_bvalid), .ram_bready(ram_bready),
    .ram_arid(ram_arid), .ram_araddr(ram_araddr), .ram_arlen(ram_arlen), .ram_arsize(ram_arsize),
    .ram_arburst(ram_arburst), .ram_arvalid(ram_arvalid), .ram_arready(ram_arready),
    .ram_rdata(ram_rdata), .ram_rresp(ram_rresp), .ram_rvalid(ram_rvalid), .ram_rready(ram_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe the handshakes that will complete at the coming edge, then move to the next negedge.
  task automatic tick();
    #1;
    if (ram_awvalid && ram_awready) begin
      aw_cnt++;
      if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
      else chk("awaddr", ram_awaddr, exp_aw.pop_front());
      chk("aw_const", {ram_awid, ram_awlen, ram_awsize, ram_awburst}, {8'h0, 8'h0, 3'd2, 2'b01});
    end
    if (ram_wvalid && ram_wready) begin
      w_cnt++;
      if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
      else chk("wdata", ram_wdata, exp_w.pop_front());
      chk("w_const", {ram_wstrb, ram_wlast}, {4'hF, 1'b1});
    end
    if (ram_arvalid && ram_arready) begin
      ar_cnt++;
      if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
      else chk("araddr", ram_araddr, exp_ar.pop_front());
      chk("ar_const", {ram_arid, ram_arlen, ram_arsize, ram_arburst}, {8'h0, 8'h0, 3'd2, 2'b01});
    end
    if (mem_rd_valid && mem_rd_ready) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("mem_rd_data", mem_rd_data, exp_rd.pop_front());
    end
    @(negedge aclk);
  endtask

  task automatic req(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_valid = 1; mem_rd = rd; mem_wr = wr; mem_addr = a; mem_wr_data = d;
    chk("req_ready", mem_ready, 1);
    if (wr) begin exp_aw.push_back(a); exp_w.push_back(d); end
    else if (rd) exp_ar.push_back(a);
    tick();
    mem_valid = 0; mem_rd = 0; mem_wr = 0;
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    chk("rst_ready", mem_ready, 0);
    chk("rst_outs", {mem_rd_valid, mem_error, ram_awvalid, ram_wvalid, ram_arvalid, ram_bready, ram_rready}, 0);
    chk("rst_rd_data", mem_rd_data, 0);
    aresetn = 1;
    tick();
    chk("idle_ready", mem_ready, 1);
    // zero-wait write
    ram_awready = 1; ram_wready = 1; ram_bvalid = 1;
    req(0, 1, 16'h0004, 32'hA5A5_0001);
    chk("wr_c1_ready", mem_ready, 0);
    tick();
    chk("wr_c2_ready", mem_ready, 0);
    chk("wr_c2_bready", ram_bready, 1);
    tick();
    ram_bvalid = 0;
    chk("wr_c3_ready", mem_ready, 1);
    chk("wr1_counts", {aw_cnt[7:0], w_cnt[7:0]}, {8'd1, 8'd1});
    // W accepted first, AW delayed to cycle 4
    ram_awready = 0; ram_wready = 1;
    req(0, 1, 16'h0008, 32'hDEAD_0002);
    tick();
    ram_wready = 0;
    chk("wr2_c2_valids", {ram_awvalid, ram_wvalid}, 2'b10);
    tick();
    chk("wr2_c3_valids", {ram_awvalid, ram_wvalid, ram_bready}, 3'b100);
    tick();
    ram_awready = 1;
    chk("wr2_c4_bready", ram_bready, 0);
    tick();
    ram_awready = 0;
    chk("wr2_c5", {ram_awvalid, ram_wvalid, ram_bready}, 3'b001);
    ram_bvalid = 1;
    tick();
    ram_bvalid = 0;
    chk("wr2_done", {mem_ready, aw_cnt[7:0], w_cnt[7:0]}, {1'b1, 8'd2, 8'd2});
    // read with 3 R wait cycles and a 2-cycle stalled completion
    ram_arready = 1;
    req(1, 0, 16'h0010, 32'h0);
    tick();
    ram_arready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait", {ram_rready, ram_arvalid, mem_rd_valid}, 3'b100);
      tick();
    end
    ram_rvalid = 1; ram_rdata = 32'h1234_5678;
    exp_rd.push_back(32'h1234_5678);
    tick();
    ram_rvalid = 0; ram_rdata = 0;
    for (int i = 0; i < 2; i++) begin
      chk("rd_hold", {ram_arvalid, mem_rd_valid, mem_rd_data}, {2'b01, 32'h1234_5678});
      tick();
    end
    mem_rd_ready = 1;
    tick();
    mem_rd_ready = 0;
    chk("rd_done", {mem_ready, mem_rd_valid, mem_error, ar_cnt[7:0]}, {3'b100, 8'd1});
    // slave error on B, then a clean read
    ram_awready = 1; ram_wready = 1;
    req(0, 1, 16'h0020, 32'h0000_0055);
    tick();
    ram_awready = 0; ram_wready = 0;
    chk("berr_before", mem_error, 0);
    ram_bvalid = 1; ram_bresp = 2'b10;
    tick();
    ram_bvalid = 0; ram_bresp = 0;
    chk("berr_after", mem_error, 1);
    ram_arready = 1;
    req(1, 0, 16'h0024, 32'h0);
    tick();
    ram_arready = 0;
    ram_rvalid = 1; ram_rdata = 32'hCAFE_F00D;
    exp_rd.push_back(32'hCAFE_F00D);
    tick();
    ram_rvalid = 0;
    mem_rd_ready = 1;
    tick();
    mem_rd_ready = 0;
    chk("berr_sticky", {mem_error, mem_ready}, 2'b11);
    // asynchronous reset while waiting for R
    ram_arready = 1;
    req(1, 0, 16'h0030, 32'h0);
    tick();
    ram_arready = 0;
    chk("rst_mid_rready", ram_rready, 1);
    aresetn = 0;
    #1;
    chk("rst_mid_drop", {ram_arvalid, ram_rready, mem_rd_valid, mem_ready, mem_error}, 0);
    @(negedge aclk);
    aresetn = 1;
    tick();
    ram_awready = 1; ram_wready = 1;
    req(0, 1, 16'h0040, 32'h0BAD_BEEF);
    tick();
    ram_awready = 0; ram_wready = 0;
    ram_bvalid = 1;
    chk("post_rst_bready", ram_bready, 1);
    tick();
    ram_bvalid = 0;
    chk("post_rst_done", {mem_ready, mem_error, aw_cnt[7:0]}, {2'b10, 8'd4});
    // request with neither rd nor wr
    ram_awready = 1; ram_wready = 1; ram_arready = 1;
    req(0, 0, 16'h0050, 32'h0);
    chk("none_valids", {ram_awvalid, ram_wvalid, ram_arvalid}, 0);
    chk("none_state", {mem_ready, mem_error}, 2'b11);
    tick();
    ram_awready = 0; ram_wready = 0; ram_arready = 0;
    chk("sb_empty", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
